status_value_queue: RTL and testbench

- Parametrised shift-queue status vector: DEPTH entries of WIDTH bits; head is always entry [0].
- Push writes at the tail; pull shifts every entry one slot toward the head.
- New over the single-bit cell:
  - multi-bit values and registered storage
  - occupancy count and full/empty flags
  - in-place update of a live entry by index
  - synchronous flush
  - sticky overflow/underflow error flags
- Sits beside the per-bit status logic as the drop-in vector used by queue-tracking blocks.

---
 rtl/status_value_queue.sv | 109 ++++++++++
 tb/tb_status_value_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/status_value_queue.sv
// Shift-queue status vector: DEPTH entries of WIDTH bits, head at entry 0.
// Supports push at tail, pull from head, in-place update, flush and sticky error flags.
module status_value_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1),
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   arst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_value_i,
  input  logic                   pull_i,
  input  logic                   upd_i,
  input  logic [IDX_W-1:0]       upd_idx_i,
  input  logic [WIDTH-1:0]       upd_value_i,
  input  logic                   err_clr_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [WIDTH*DEPTH-1:0] vector_o,
  output logic [DEPTH-1:0]       valid_o,
  output logic [CNT_W-1:0]       count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   push_ack_o,
  output logic                   pull_ack_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_n [DEPTH];
  logic [CNT_W-1:0] count_q, count_n, push_slot;
  logic [DEPTH-1:0] valid_q, valid_n;
  logic             full_q, empty_q, ovf_q, unf_q;
  logic             ovf_set, unf_set, upd_ok;

  assign pull_ack_o = pull_i & ~empty_q & ~flush_i;
  assign push_ack_o = push_i & (~full_q | pull_ack_o) & ~flush_i;
  assign ovf_set    = push_i & ~push_ack_o & ~flush_i;
  assign unf_set    = pull_i & empty_q & ~push_i & ~flush_i;
  assign upd_ok     = upd_i & (CNT_W'(upd_idx_i) < count_q);
  // With a pull in the same cycle the tail has already moved down one slot.
  assign push_slot  = pull_ack_o ? count_q - CNT_W'(1) : count_q;

  always_comb begin
    mem_n   = mem_q;
    count_n = count_q;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) mem_n[i] = '0;
      count_n = '0;
    end else begin
      if (pull_ack_o) begin
        for (int i = 0; i < DEPTH - 1; i++) mem_n[i] = mem_q[i + 1];
        mem_n[DEPTH-1] = '0;
      end
      if (push_ack_o) begin
        for (int i = 0; i < DEPTH; i++)
          if (CNT_W'(i) == push_slot) mem_n[i] = push_value_i;
      end
      // Update follows the shift; an index-0 update under pull leaves with the head.
      if (upd_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (pull_ack_o) begin
            if (CNT_W'(i + 1) == CNT_W'(upd_idx_i)) mem_n[i] = upd_value_i;
          end else begin
            if (CNT_W'(i) == CNT_W'(upd_idx_i)) mem_n[i] = upd_value_i;
          end
        end
      end
      count_n = count_q + CNT_W'(push_ack_o) - CNT_W'(pull_ack_o);
    end
    for (int i = 0; i < DEPTH; i++) valid_n[i] = (CNT_W'(i) < count_n);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      count_q <= '0;
      valid_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      mem_q   <= mem_n;
      count_q <= count_n;
      valid_q <= valid_n;
      full_q  <= (count_n == CNT_W'(DEPTH));
      empty_q <= (count_n == '0);
      ovf_q   <= ovf_set | (ovf_q & ~err_clr_i);
      unf_q   <= unf_set | (unf_q & ~err_clr_i);
    end
  end

  always_comb begin
    vector_o = '0;
    for (int i = 0; i < DEPTH; i++) vector_o[i*WIDTH +: WIDTH] = mem_q[i];
  end

  assign head_o      = mem_q[0];
  assign valid_o     = valid_q;
  assign count_o     = count_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

endmodule

// File: tb/tb_status_value_queue.sv
// Bench for status_value_queue: queue-based reference model plus a pull scoreboard
// pairing each expected departing head with the head observed at the pull.
module tb_status_value_queue;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        flush_i, push_i, pull_i, upd_i, err_clr_i;
  logic [7:0]  push_value_i, upd_value_i;
  logic [2:0]  upd_idx_i;
  logic [7:0]  head_o;
  logic [63:0] vector_o;
  logic [7:0]  valid_o;
  logic [3:0]  count_o;
  logic        full_o, empty_o, push_ack_o, pull_ack_o, overflow_o, underflow_o;

  status_value_queue #(.WIDTH(8), .DEPTH(8)) dut (
    .clk_i(clk_i), .arst_i(arst_i), .flush_i(flush_i), .push_i(push_i),
    .push_value_i(push_value_i), .pull_i(pull_i), .upd_i(upd_i),
    .upd_idx_i(upd_idx_i), .upd_value_i(upd_value_i), .err_clr_i(err_clr_i),
    .head_o(head_o), .vector_o(vector_o), .valid_o(valid_o), .count_o(count_o),
    .full_o(full_o), .empty_o(empty_o), .push_ack_o(push_ack_o),
    .pull_ack_o(pull_ack_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_pull_q[$];
  logic [7:0] act_pull_q[$];
  logic       ovf_m, unf_m;
  logic       exp_push_ack, exp_pull_ack, obs_push_ack, obs_pull_ack;

  function automatic logic [63:0] model_vec();
    logic [63:0] v = '0;
    for (int i = 0; i < model_q.size(); i++) v[i*8 +: 8] = model_q[i];
    return v;
  endfunction

  function automatic logic [7:0] model_valid();
    logic [8:0] t = (9'd1 << model_q.size()) - 9'd1;
    return t[7:0];
  endfunction

  task automatic idle_inputs();
    flush_i = 0; push_i = 0; pull_i = 0; upd_i = 0; err_clr_i = 0;
    push_value_i = '0; upd_value_i = '0; upd_idx_i = '0;
  endtask

  // Drives one cycle from #1 after an edge, records acks, advances the model.
  task automatic drive(input logic ps, input logic [7:0] pv, input logic pl,
                       input logic up, input logic [2:0] ix, input logic [7:0] uv,
                       input logic fl, input logic cl);
    int sz = model_q.size();
    push_i = ps; push_value_i = pv; pull_i = pl; upd_i = up; upd_idx_i = ix;
    upd_value_i = uv; flush_i = fl; err_clr_i = cl;
    #1;
    exp_pull_ack = pl & (sz > 0) & !fl;
    exp_push_ack = ps & ((sz < 8) | exp_pull_ack) & !fl;
    obs_push_ack = push_ack_o;
    obs_pull_ack = pull_ack_o;
    if (exp_pull_ack) begin
      exp_pull_q.push_back(model_q[0]);
      act_pull_q.push_back(head_o);
    end
    @(posedge clk_i); #1;
    if (fl) model_q.delete();
    else begin
      if (exp_pull_ack) void'(model_q.pop_front());
      if (up && (int'(ix) < sz)) begin
        if (exp_pull_ack) begin
          if (ix != 0) model_q[ix - 1] = uv;
        end else model_q[ix] = uv;
      end
      if (exp_push_ack) model_q.push_back(pv);
    end
    ovf_m = (ps & !exp_push_ack & !fl) ? 1'b1 : (cl ? 1'b0 : ovf_m);
    unf_m = (pl & (sz == 0) & !ps & !fl) ? 1'b1 : (cl ? 1'b0 : unf_m);
    idle_inputs();
  endtask

  task automatic restart();
    drive(0, 0, 0, 0, 0, 0, 1, 1);
    exp_pull_q.delete(); act_pull_q.delete();
  endtask

  task automatic test_reset();
    arst_i = 1; idle_inputs();
    model_q.delete(); ovf_m = 0; unf_m = 0;
    @(posedge clk_i); #1;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin errors++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty_o, full_o); end
    checks++; if (valid_o !== 8'h00 || vector_o !== 64'h0 || head_o !== 8'h00) begin errors++; $display("FAIL reset_data got valid=%h vec=%h head=%h exp 0", valid_o, vector_o, head_o); end
    checks++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL reset_err got ovf=%b unf=%b exp 0 0", overflow_o, underflow_o); end
    arst_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_push3();
    restart();
    drive(1, 8'h11, 0, 0, 0, 0, 0, 0);
    checks++; if (empty_o !== 1'b0 || head_o !== 8'h11) begin errors++; $display("FAIL push3_first got empty=%b head=%h exp empty=0 head=11", empty_o, head_o); end
    drive(1, 8'h22, 0, 0, 0, 0, 0, 0);
    drive(1, 8'h33, 0, 0, 0, 0, 0, 0);
    checks++; if (count_o !== 4'd3 || valid_o !== 8'b0000_0111) begin errors++; $display("FAIL push3_count got cnt=%0d valid=%b exp 3 00000111", count_o, valid_o); end
    checks++; if (head_o !== 8'h11 || vector_o[23:16] !== 8'h33) begin errors++; $display("FAIL push3_data got head=%h e2=%h exp 11 33", head_o, vector_o[23:16]); end
    checks++; if (vector_o !== model_vec()) begin errors++; $display("FAIL push3_vec got=%h exp=%h", vector_o, model_vec()); end
  endtask

  task automatic test_overflow();
    logic [63:0] snap;
    restart();
    for (int v = 1; v <= 8; v++) drive(1, 8'(v), 0, 0, 0, 0, 0, 0);
    checks++; if (full_o !== 1'b1 || count_o !== 4'd8) begin errors++; $display("FAIL ovf_full got full=%b cnt=%0d exp 1 8", full_o, count_o); end
    snap = vector_o;
    drive(1, 8'h99, 0, 0, 0, 0, 0, 0);
    checks++; if (obs_push_ack !== 1'b0 || overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_reject got ack=%b ovf=%b exp 0 1", obs_push_ack, overflow_o); end
    checks++; if (vector_o !== snap) begin errors++; $display("FAIL ovf_unchanged got=%h exp=%h", vector_o, snap); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_o); end
    drive(1, 8'h99, 1, 0, 0, 0, 0, 0);
    checks++; if (obs_push_ack !== 1'b1 || obs_pull_ack !== 1'b1) begin errors++; $display("FAIL ovf_pushpull_ack got push=%b pull=%b exp 1 1", obs_push_ack, obs_pull_ack); end
    checks++; if (head_o !== 8'h02 || vector_o[63:56] !== 8'h99 || count_o !== 4'd8) begin errors++; $display("FAIL ovf_pushpull got head=%h e7=%h cnt=%0d exp 02 99 8", head_o, vector_o[63:56], count_o); end
    checks++; if (act_pull_q.size() != 1 || act_pull_q[0] !== 8'h01) begin errors++; $display("FAIL ovf_pulled got n=%0d exp one value 01", act_pull_q.size()); end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow_o); end
  endtask

  task automatic test_underflow();
    restart();
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    checks++; if (underflow_o !== 1'b1 || obs_pull_ack !== 1'b0) begin errors++; $display("FAIL unf_set got unf=%b ack=%b exp 1 0", underflow_o, obs_pull_ack); end
    drive(1, 8'h5A, 1, 0, 0, 0, 0, 0);
    checks++; if (obs_pull_ack !== 1'b0 || obs_push_ack !== 1'b1) begin errors++; $display("FAIL unf_pp_ack got pull=%b push=%b exp 0 1", obs_pull_ack, obs_push_ack); end
    checks++; if (count_o !== 4'd1 || head_o !== 8'h5A || underflow_o !== 1'b1) begin errors++; $display("FAIL unf_pp got cnt=%0d head=%h unf=%b exp 1 5a 1", count_o, head_o, underflow_o); end
    restart();
    drive(1, 8'h5B, 1, 0, 0, 0, 0, 0);
    checks++; if (underflow_o !== 1'b0 || head_o !== 8'h5B) begin errors++; $display("FAIL unf_pp_noflag got unf=%b head=%h exp 0 5b", underflow_o, head_o); end
  endtask

  task automatic test_update();
    restart();
    drive(1, 8'h0A, 0, 0, 0, 0, 0, 0);
    drive(1, 8'h0B, 0, 0, 0, 0, 0, 0);
    drive(1, 8'h0C, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 1, 3'd1, 8'h0E, 0, 0);
    checks++; if (vector_o !== 64'h0C0E || count_o !== 4'd2) begin errors++; $display("FAIL upd_pull got vec=%h cnt=%0d exp 0c0e 2", vector_o, count_o); end
    drive(0, 0, 1, 1, 3'd0, 8'h77, 0, 0);
    checks++; if (vector_o !== 64'h0C || count_o !== 4'd1) begin errors++; $display("FAIL upd_drop got vec=%h cnt=%0d exp 0c 1", vector_o, count_o); end
    drive(0, 0, 0, 1, 3'd5, 8'h55, 0, 0);
    checks++; if (vector_o !== 64'h0C || overflow_o !== 1'b0 || underflow_o !== 1'b0) begin errors++; $display("FAIL upd_oob got vec=%h ovf=%b unf=%b exp 0c 0 0", vector_o, overflow_o, underflow_o); end
    drive(0, 0, 0, 1, 3'd0, 8'h66, 0, 0);
    checks++; if (head_o !== 8'h66) begin errors++; $display("FAIL upd_head got=%h exp=66", head_o); end
  endtask

  task automatic test_flush();
    restart();
    for (int v = 0; v < 4; v++) drive(1, 8'(8'h40 + v), 0, 0, 0, 0, 0, 0);
    drive(1, 8'hFF, 0, 0, 0, 0, 1, 0);
    checks++; if (obs_push_ack !== 1'b0) begin errors++; $display("FAIL flush_ack got=%b exp=0", obs_push_ack); end
    checks++; if (count_o !== 4'd0 || vector_o !== 64'h0 || overflow_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL flush_state got cnt=%0d vec=%h ovf=%b empty=%b exp 0 0 0 1", count_o, vector_o, overflow_o, empty_o); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    restart();
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 99) < 60), 8'($urandom), ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 25), 3'($urandom_range(0, 7)), 8'($urandom),
            ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10));
      if (obs_push_ack !== exp_push_ack || obs_pull_ack !== exp_pull_ack) begin
        bad++; $display("FAIL b2b_ack cyc=%0d got push=%b pull=%b exp %b %b", n, obs_push_ack, obs_pull_ack, exp_push_ack, exp_pull_ack);
      end
      if (vector_o !== model_vec() || valid_o !== model_valid() || count_o !== 4'(model_q.size())) begin
        bad++; $display("FAIL b2b_state cyc=%0d got vec=%h valid=%h cnt=%0d exp %h %h %0d", n, vector_o, valid_o, count_o, model_vec(), model_valid(), model_q.size());
      end
      if (full_o !== (model_q.size() == 8) || empty_o !== (model_q.size() == 0) || overflow_o !== ovf_m || underflow_o !== unf_m) begin
        bad++; $display("FAIL b2b_flags cyc=%0d got full=%b empty=%b ovf=%b unf=%b exp ovf=%b unf=%b cnt=%0d", n, full_o, empty_o, overflow_o, underflow_o, ovf_m, unf_m, model_q.size());
      end
      while (exp_pull_q.size() > 0) begin
        logic [7:0] e = exp_pull_q.pop_front();
        logic [7:0] a = act_pull_q.pop_front();
        if (a !== e) begin bad++; $display("FAIL b2b_pull cyc=%0d got=%h exp=%h", n, a, e); end
      end
    end
    checks++;
    errors += bad;
  endtask

  task automatic test_async_reset();
    restart();
    for (int v = 0; v < 5; v++) drive(1, 8'(8'hC0 + v), 0, 0, 0, 0, 0, 0);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL arst_pre got=%0d exp=5", count_o); end
    #2 arst_i = 1;
    #1;
    checks++; if (count_o !== 4'd0 || vector_o !== 64'h0 || empty_o !== 1'b1 || valid_o !== 8'h0) begin errors++; $display("FAIL arst_mid got cnt=%0d vec=%h empty=%b valid=%h exp 0 0 1 0", count_o, vector_o, empty_o, valid_o); end
    model_q.delete(); ovf_m = 0; unf_m = 0;
    @(posedge clk_i); #1;
    arst_i = 0;
    @(posedge clk_i); #1;
    drive(1, 8'h42, 0, 0, 0, 0, 0, 0);
    checks++; if (head_o !== 8'h42 || count_o !== 4'd1 || vector_o !== 64'h42) begin errors++; $display("FAIL arst_after got head=%h cnt=%0d vec=%h exp 42 1 42", head_o, count_o, vector_o); end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_overflow();
    test_underflow();
    test_update();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
